// File: rtl/pll_reset_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_reset_seq_pkg;

  // Sequencer states, in release order.
  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StStable   = 2'd1,
    StHold     = 2'd2,
    StRun      = 2'd3
  } pll_seq_state_e;

  localparam int unsigned DefSyncStages      = 2;
  localparam int unsigned DefLockStableCycles = 1024;
  localparam int unsigned DefResetHoldCycles  = 16;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchroniser with asynchronous active-low reset to 0.
module cdc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Two-phase reset release for one PLL clock domain, driven by the PLL lock flag.
// Optional feature macro: PLL_RESET_SEQ_LOSS_COUNT_EN enables the lock-loss pulse
// and the saturating lock-loss counter; without it both outputs are tied to 0.
module pll_reset_sequencer
  import pll_reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DefSyncStages,
  parameter int unsigned LOCK_STABLE_CYCLES = DefLockStableCycles,
  parameter int unsigned RESET_HOLD_CYCLES  = DefResetHoldCycles,
  parameter int unsigned CNT_W              = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             locked_i,
  output logic             rst_early_n_o,
  output logic             rst_n_o,
  output logic             lock_lost_o,
  output logic [CNT_W-1:0] lock_loss_count_o
);

  localparam int unsigned MaxCycles =
      (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned SeqCntW = $clog2(MaxCycles) + 1;

  // Terminal counts: the counter is 0 on the entry edge, so the exit edge sees N-1.
  localparam logic [SeqCntW-1:0] StableLast = SeqCntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [SeqCntW-1:0] HoldLast   = SeqCntW'(RESET_HOLD_CYCLES - 1);

  logic               w_lk;
  pll_seq_state_e     r_state;
  logic [SeqCntW-1:0] r_cnt;
  logic               r_rst_early_n;
  logic               r_rst_n;

  cdc_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (locked_i),
    .q_o    (w_lk)
  );

  // Sequencer FSM; reset outputs are registered from the state being entered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= StWaitLock;
      r_cnt         <= '0;
      r_rst_early_n <= 1'b0;
      r_rst_n       <= 1'b0;
    end else if (!w_lk) begin
      // Lock dropped: restart from any state.
      r_state       <= StWaitLock;
      r_cnt         <= '0;
      r_rst_early_n <= 1'b0;
      r_rst_n       <= 1'b0;
    end else begin
      unique case (r_state)
        StWaitLock: begin
          r_state       <= StStable;
          r_cnt         <= '0;
          r_rst_early_n <= 1'b0;
          r_rst_n       <= 1'b0;
        end
        StStable: begin
          if (r_cnt == StableLast) begin
            r_state       <= StHold;
            r_cnt         <= '0;
            r_rst_early_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StHold: begin
          if (r_cnt == HoldLast) begin
            r_state <= StRun;
            r_cnt   <= '0;
            r_rst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StRun: begin
          r_rst_early_n <= 1'b1;
          r_rst_n       <= 1'b1;
        end
        default: begin
          r_state       <= StWaitLock;
          r_cnt         <= '0;
          r_rst_early_n <= 1'b0;
          r_rst_n       <= 1'b0;
        end
      endcase
    end
  end

  assign rst_early_n_o = r_rst_early_n;
  assign rst_n_o       = r_rst_n;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             r_lock_lost;
  logic [CNT_W-1:0] r_loss_count;
  logic             w_loss_event;

  // Only a loss while fully released is reported; earlier drops are silent restarts.
  assign w_loss_event = (r_state == StRun) && !w_lk;

  // Lock-loss pulse and saturating event counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock_lost  <= 1'b0;
      r_loss_count <= '0;
    end else begin
      r_lock_lost <= w_loss_event;
      if (w_loss_event && (r_loss_count != CntMax)) begin
        r_loss_count <= r_loss_count + 1'b1;
      end
    end
  end

  assign lock_lost_o       = r_lock_lost;
  assign lock_loss_count_o = r_loss_count;
`else
  assign lock_lost_o       = 1'b0;
  assign lock_loss_count_o = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed table-driven bench for pll_reset_sequencer (SYNC=2, STABLE=8, HOLD=4, CNT_W=2).
module tb_pll_reset_sequencer;

  localparam int unsigned CntW = 2;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  localparam bit LossEn = 1'b1;
`else
  localparam bit LossEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n_i = 1'b1;
  logic            locked_i = 1'b0;
  logic            rst_early_n_o;
  logic            rst_n_o;
  logic            lock_lost_o;
  logic [CntW-1:0] lock_loss_count_o;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .RESET_HOLD_CYCLES (4),
    .CNT_W             (CntW)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n_i),
    .locked_i         (locked_i),
    .rst_early_n_o    (rst_early_n_o),
    .rst_n_o          (rst_n_o),
    .lock_lost_o      (lock_lost_o),
    .lock_loss_count_o(lock_loss_count_o)
  );

  // One record per clock edge: inputs applied before the edge, outputs expected after it.
  // exp packs {rst_early_n, rst_n, lock_lost, count[1:0]}.
  typedef struct {
    logic       rst_n;
    logic       locked;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int n, string name, logic r, logic l, logic e, logic m,
                              logic lost, int cnt);
    vec_t v;
    logic [1:0] c;
    c = LossEn ? 2'(cnt) : 2'd0;
    for (int i = 0; i < n; i++) begin
      v.rst_n  = r;
      v.locked = l;
      v.exp    = {e, m, lost & LossEn, c};
      v.name   = name;
      vecs.push_back(v);
    end
  endfunction

  // k-th lock loss from RUN, then relock and full release back into RUN.
  function automatic void add_loss(int k);
    int prev;
    int cur;
    prev = (k - 1 > 3) ? 3 : k - 1;
    cur  = (k > 3) ? 3 : k;
    add(2, "loss_pre",      1'b1, 1'b0, 1'b1, 1'b1, 1'b0, prev);
    add(1, "loss_hit",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cur);
    add(1, "loss_wait",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur);
    add(10, "relock_stable", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cur);
    add(4, "relock_hold",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, cur);
    add(3, "relock_run",    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, cur);
  endfunction

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {rst_early_n_o, rst_n_o, lock_lost_o, lock_loss_count_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {early,main,lost,cnt}=%b required %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vectors();
    foreach (vecs[i]) begin
      rst_n_i  = vecs[i].rst_n;
      locked_i = vecs[i].locked;
      step();
      check($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].exp);
    end
    vecs.delete();
  endtask

  initial begin
    locked_i = 1'b1;
    #2 rst_n_i = 1'b0;
    #1 check("reset_async_entry", 5'b0);

    // Power-up with lock high throughout, then five losses in RUN (count saturates at 3).
    add(3, "por_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(10, "por_stable", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(4, "por_hold_phase", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(3, "por_run", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    for (int k = 1; k <= 5; k++) add_loss(k);
    run_vectors();

    // Sixth loss, relock, stop mid-HOLD and pulse the async reset between edges.
    locked_i = 1'b0;
    repeat (4) step();
    locked_i = 1'b1;
    repeat (11) step();
    check("mid_hold_before_reset", {1'b1, 1'b0, 1'b0, (LossEn ? 2'd3 : 2'd0)});
    #2 rst_n_i = 1'b0;
    #1 check("async_reset_mid_hold", 5'b0);

    // Release, then a one-cycle lock glitch five cycles into STABLE restarts the sequence.
    add(1, "rst_held", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(7, "g_stable", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(1, "g_glitch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add(10, "g_restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(4, "g_hold", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(3, "g_run", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run_vectors();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
